// File: rtl/lc3b_types.sv
// ============================================================================
// Package  : lc3b_types
// Desc     : Shared word/line/tag types and the victim-cache FSM states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_line;
  typedef logic [11:0]  lc3b_c_tag;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    WB     = 2'd2,
    FILL   = 2'd3
  } vc_state_t;

  function automatic lc3b_word line_addr(input lc3b_c_tag tag);
    return {tag, 4'b0000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/vc_tag_cam.sv
// ============================================================================
// Module   : vc_tag_cam
// Desc     : Tag/valid/dirty store with parallel compare for the victim cache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_tag_cam
  import lc3b_types::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [11:0]        lookup_tag_i,
  input  logic               wr_en_i,
  input  logic [2:0]         wr_idx_i,
  input  logic [11:0]        wr_tag_i,
  input  logic               wr_dirty_i,
  input  logic               clr_en_i,
  input  logic [2:0]         clr_idx_i,
  input  logic [2:0]         rd_idx_i,
  output logic               hit_o,
  output logic [2:0]         hit_idx_o,
  output logic               free_o,
  output logic [2:0]         free_idx_o,
  output logic [ENTRIES-1:0] valid_o,
  output logic [ENTRIES-1:0] dirty_o,
  output logic [11:0]        rd_tag_o
);

  lc3b_c_tag          tag_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] dirty_q;
  logic [ENTRIES-1:0] w_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < ENTRIES; i++) tag_q[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (wr_en_i && (wr_idx_i == 3'(i))) begin
          tag_q[i]   <= wr_tag_i;
          valid_q[i] <= 1'b1;
          dirty_q[i] <= wr_dirty_i;
        end else if (clr_en_i && (clr_idx_i == 3'(i))) begin
          valid_q[i] <= 1'b0;
          dirty_q[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_match
    assign w_match[g] = valid_q[g] && (tag_q[g] == lookup_tag_i);
  end

  // Scan high-to-low so the lowest matching / invalid index wins.
  always_comb begin
    hit_o      = 1'b0;
    hit_idx_o  = '0;
    free_o     = 1'b0;
    free_idx_o = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        hit_o     = 1'b1;
        hit_idx_o = 3'(i);
      end
      if (!valid_q[i]) begin
        free_o     = 1'b1;
        free_idx_o = 3'(i);
      end
    end
  end

  assign valid_o  = valid_q;
  assign dirty_o  = dirty_q;
  assign rd_tag_o = tag_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/vc_ctrl.sv
// ============================================================================
// Module   : vc_ctrl
// Desc     : Victim-cache controller: lookup/swap, dirty write-back and fill.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_ctrl
  import lc3b_types::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vc_req,
  input  logic [15:0]  vc_addr,
  input  logic         vc_evict_valid,
  input  logic [15:0]  vc_evict_addr,
  input  logic [127:0] vc_evict_data,
  input  logic         vc_evict_dirty,
  output logic         vc_resp,
  output logic [127:0] vc_rdata,
  output logic         vc_rdirty,
  input  logic [127:0] arr_line0,
  input  logic [127:0] arr_line1,
  input  logic [127:0] arr_line2,
  input  logic [127:0] arr_line3,
  input  logic [127:0] arr_line4,
  input  logic [127:0] arr_line5,
  input  logic [127:0] arr_line6,
  input  logic [127:0] arr_line7,
  output logic         arr_write,
  output logic [2:0]   arr_index,
  output logic [127:0] arr_wdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  vc_state_t  state_q, state_d;
  lc3b_c_tag  req_tag_q;
  lc3b_c_tag  ev_tag_q;
  lc3b_c_line ev_data_q;
  logic       ev_valid_q, ev_dirty_q;
  logic [2:0] victim_q, victim_d;
  logic [2:0] fifo_ptr_q, fifo_ptr_d;
  logic       from_fifo_q, from_fifo_d;

  lc3b_c_line         w_lines [ENTRIES];
  logic               w_hit, w_free, w_cam_wr, w_cam_clr;
  logic [2:0]         w_hit_idx, w_free_idx;
  logic [ENTRIES-1:0] w_valid, w_dirty;
  lc3b_c_tag          w_rd_tag;
  logic               w_unused;

  assign w_lines[0] = arr_line0;
  assign w_lines[1] = arr_line1;
  assign w_lines[2] = arr_line2;
  assign w_lines[3] = arr_line3;
  assign w_lines[4] = arr_line4;
  assign w_lines[5] = arr_line5;
  assign w_lines[6] = arr_line6;
  assign w_lines[7] = arr_line7;

  // Byte offsets never matter: everything is tracked per 16-byte line.
  assign w_unused = ^{vc_addr[3:0], vc_evict_addr[3:0]};

  vc_tag_cam #(.ENTRIES(ENTRIES)) u_cam (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_tag_i (req_tag_q),
    .wr_en_i      (w_cam_wr),
    .wr_idx_i     (arr_index),
    .wr_tag_i     (ev_tag_q),
    .wr_dirty_i   (ev_dirty_q),
    .clr_en_i     (w_cam_clr),
    .clr_idx_i    (w_hit_idx),
    .rd_idx_i     (victim_q),
    .hit_o        (w_hit),
    .hit_idx_o    (w_hit_idx),
    .free_o       (w_free),
    .free_idx_o   (w_free_idx),
    .valid_o      (w_valid),
    .dirty_o      (w_dirty),
    .rd_tag_o     (w_rd_tag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fifo_ptr_q  <= '0;
      victim_q    <= '0;
      from_fifo_q <= 1'b0;
      req_tag_q   <= '0;
      ev_tag_q    <= '0;
      ev_data_q   <= '0;
      ev_valid_q  <= 1'b0;
      ev_dirty_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_ptr_q  <= fifo_ptr_d;
      victim_q    <= victim_d;
      from_fifo_q <= from_fifo_d;
      if ((state_q == IDLE) && vc_req) begin
        req_tag_q  <= vc_addr[15:4];
        ev_tag_q   <= vc_evict_addr[15:4];
        ev_data_q  <= vc_evict_data;
        ev_valid_q <= vc_evict_valid;
        ev_dirty_q <= vc_evict_dirty;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    from_fifo_d  = from_fifo_q;
    fifo_ptr_d   = fifo_ptr_q;
    vc_resp      = 1'b0;
    vc_rdata     = '0;
    vc_rdirty    = 1'b0;
    arr_write    = 1'b0;
    arr_index    = '0;
    arr_wdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    w_cam_wr     = 1'b0;
    w_cam_clr    = 1'b0;

    case (state_q)
      IDLE: begin
        if (vc_req) state_d = LOOKUP;
      end

      LOOKUP: begin
        if (w_hit) begin
          vc_resp   = 1'b1;
          vc_rdata  = w_lines[w_hit_idx];
          vc_rdirty = w_dirty[w_hit_idx];
          // A hit with no eviction hands the line to L1, so the slot is freed.
          if (ev_valid_q) begin
            arr_write = 1'b1;
            arr_index = w_hit_idx;
            arr_wdata = ev_data_q;
            w_cam_wr  = 1'b1;
          end else begin
            w_cam_clr = 1'b1;
          end
          state_d = IDLE;
        end else begin
          victim_d    = w_free ? w_free_idx : fifo_ptr_q;
          from_fifo_d = !w_free;
          if (ev_valid_q && w_valid[victim_d] && w_dirty[victim_d]) state_d = WB;
          else                                                      state_d = FILL;
        end
      end

      WB: begin
        pmem_write   = 1'b1;
        pmem_address = line_addr(w_rd_tag);
        pmem_wdata   = w_lines[victim_q];
        if (pmem_resp) state_d = FILL;
      end

      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = line_addr(req_tag_q);
        if (pmem_resp) begin
          vc_resp  = 1'b1;
          vc_rdata = pmem_rdata;
          if (ev_valid_q) begin
            arr_write = 1'b1;
            arr_index = victim_q;
            arr_wdata = ev_data_q;
            w_cam_wr  = 1'b1;
            if (from_fifo_q) fifo_ptr_d = fifo_ptr_q + 3'd1;
          end
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/vc_ctrl.md
# vc_ctrl

Victim-cache controller for the lc3b memory hierarchy. It sits between the L1 data cache miss path and physical memory, and owns tag, valid and dirty state for eight fully associative 128-bit victim lines. It reads all eight lines from the victim data array and drives that array's single write port. On an L1 miss it looks up the requested line, swaps it with the L1 eviction on a hit, and on a miss writes back a dirty victim if needed, then fills from memory.

## Interface
- `ENTRIES`, default 8: victim lines; fixed at 8 (3-bit index).
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `vc_req`, in, 1: L1 miss request; level, held until `vc_resp`.
- `vc_addr`, in, 16: requested byte address; tag = [15:4].
- `vc_evict_valid`, in, 1: L1 supplies an evicted line with this request.
- `vc_evict_addr`, in, 16: address of the evicted line.
- `vc_evict_data`, in, 128: data of the evicted line.
- `vc_evict_dirty`, in, 1: evicted line is dirty.
- `vc_resp`, out, 1: one-cycle completion pulse.
- `vc_rdata`, out, 128: requested line; valid only while `vc_resp`=1.
- `vc_rdirty`, out, 1: returned line is dirty (hit on a dirty entry).
- `arr_line0` … `arr_line7`, in, 128 each: current contents of array entries 0–7.
- `arr_write`, out, 1: array write strobe.
- `arr_index`, out, 3: array write index.
- `arr_wdata`, out, 128: array write data.
- `pmem_read`, `pmem_write`, out, 1 each: memory request, held until `pmem_resp`.
- `pmem_address`, out, 16: line address, [3:0]=0.
- `pmem_wdata`, out, 128: write-back data.
- `pmem_rdata`, in, 128: fill data.
- `pmem_resp`, in, 1: memory done.

## Operation
- **Reset:** valid[7:0]=0, dirty=0, fifo_ptr=0, state=IDLE. All outputs are 0 asynchronously.
- **IDLE:** on `vc_req`=1, capture `vc_addr` and all `vc_evict_*` inputs into registers, then go to LOOKUP.
- **LOOKUP:** compare the captured tag against all valid tags.
  - **Hit at entry h:**
    - Assert `vc_resp` with `vc_rdata`=arr_line[h] and `vc_rdirty`=dirty[h].
    - If evict_valid: write the eviction into h (arr_write=1, index h; tag and dirty updated).
    - Otherwise: clear valid[h].
    - fifo_ptr is unchanged. Go to IDLE.
  - **Miss:** select victim slot v.
    - v is the lowest-index invalid entry if any exists; otherwise v = fifo_ptr.
    - If evict_valid and valid[v] and dirty[v]: go to WB.
    - Otherwise: go to FILL.
- **WB:** `pmem_write`=1, `pmem_address`={tag[v],4'b0}, `pmem_wdata`=arr_line[v]. On `pmem_resp`, go to FILL.
- **FILL:** `pmem_read`=1, `pmem_address`={captured tag,4'b0}. On `pmem_resp`, in the same cycle:
  - Assert `vc_resp` with `vc_rdata`=`pmem_rdata` and `vc_rdirty`=0.
  - If evict_valid: write the eviction into v and set valid[v]=1. If v was chosen by fifo_ptr, advance fifo_ptr by 1 modulo 8 (7 wraps to 0).
  - Go to IDLE.
- **No eviction on a miss:** the array is never written and fifo_ptr does not move.
- **Clean victim on a miss:** the victim is overwritten silently; no WB.
- **Protocol constraints:** an evict address already resident in the victim cache is illegal (L1 and victim cache are exclusive); no check is required. `pmem_resp` outside WB/FILL is ignored.

## Timing
- Request accepted at edge N (state becomes LOOKUP).
- Hit: `vc_resp` and `arr_write` are both in cycle N+1.
- Miss: `pmem_*` is asserted from cycle N+1, combinationally from state. `vc_resp` occurs in the `pmem_resp` cycle of FILL.
- L1 drops `vc_req` at the edge ending the `vc_resp` cycle. The controller is back in IDLE at that edge, so back-to-back requests are spaced by at least one IDLE cycle.
- Tag, valid, dirty and fifo_ptr update at the same edge as the array write.
- Reset mid-WB or mid-FILL: `pmem_read`/`pmem_write` drop immediately and all state is cleared; the outstanding memory transfer is abandoned.

## Structure
- Package `lc3b_types` holds:
  - `lc3b_word` (16 bits).
  - `lc3b_c_line` (128 bits).
  - `lc3b_c_tag` (12 bits).
  - The `vc_state_t` enum {IDLE, LOOKUP, WB, FILL}.
- One natural sub-module: `vc_tag_cam`. It holds the 8 tags and valid/dirty bits, performs the parallel compare, and outputs hit, the hit index, and the lowest-invalid index.
- The FSM, fifo_ptr and datapath muxes live in `vc_ctrl`.

## Test plan
- **Reset and cold miss:** after reset, request 0x1230 with an eviction of 0x4560 (clean) → FILL with `pmem_address`=0x1230; `vc_resp` shows `pmem_rdata`; entry 0 holds tag 0x456, valid; fifo_ptr stays 0.
- **Hit/swap:** fill 3 entries, then request 0x4560 evicting 0x7890 dirty → `vc_resp` at N+1 with the stored data and `vc_rdirty`=0; same index rewritten with tag 0x789, dirty=1; no pmem activity.
- **Dirty write-back:** fill all 8 entries with dirty lines, then miss with an eviction → `pmem_write` to entry 0's address with its data; after `pmem_resp`, `pmem_read` of the request; eviction written to index 0; fifo_ptr=1.
- **FIFO wrap:** 9 further full-cache miss-with-evict cycles → victims are indices 1..7, then 0, then 1; fifo_ptr wraps from 7 to 0.
- **Hit without eviction:** → `vc_resp` at N+1 and valid[h] cleared. A subsequent miss then selects h as the lowest invalid entry.
- **Reset during FILL:** assert `rst_n`=0 while `pmem_read`=1 → `pmem_read` goes to 0 immediately and all entries are invalid; the next request misses.
